// File: rtl/jtag_tap_responder_if.sv
// JTAG pin and scan-chain bundle for jtag_tap_responder.
//   tck_i/tms_i/tdi_i/trst_n_i : raw JTAG pins from the test host (async)
//   tdo_o/tdo_oe_o             : serial out and its output enable
//   ir_o                       : current (updated) instruction
//   chain_*                    : internal scan chain port (tdi out, tdo in,
//                                capture/shift/update one-cycle strobes)
// slave = the TAP responder, master = whoever drives the pins / owns the chain.
interface jtag_tap_responder_if;
  logic       tck_i;
  logic       tms_i;
  logic       tdi_i;
  logic       trst_n_i;
  logic       tdo_o;
  logic       tdo_oe_o;
  logic [3:0] ir_o;
  logic       chain_tdi_o;
  logic       chain_tdo_i;
  logic       chain_capture_o;
  logic       chain_shift_o;
  logic       chain_update_o;

  modport slave (
    input  tck_i, tms_i, tdi_i, trst_n_i, chain_tdo_i,
    output tdo_o, tdo_oe_o, ir_o, chain_tdi_o,
           chain_capture_o, chain_shift_o, chain_update_o
  );

  modport master (
    output tck_i, tms_i, tdi_i, trst_n_i, chain_tdo_i,
    input  tdo_o, tdo_oe_o, ir_o, chain_tdi_o,
           chain_capture_o, chain_shift_o, chain_update_o
  );
endinterface

// File: rtl/jtag_tap_responder.sv
// Oversampled IEEE 1149.1 TAP responder running entirely on wb_clk_i.
// JTAG pins are synchronized, tck edges are detected, and the 16-state TAP
// controller plus IR / IDCODE / BYPASS / external-chain steering advance on
// those detected edges.
//   wb_clk_i : system clock
//   wb_rst_i : synchronous active-high reset
//   jtag     : pins, tdo, ir and scan-chain strobes (see jtag_tap_responder_if)
module jtag_tap_responder #(
  parameter logic [31:0] IDCODE    = 32'h1000_05FF,
  parameter logic [3:0]  IR_SCAN   = 4'h3,
  parameter logic [3:0]  IR_IDCODE = 4'h1
) (
  input logic                 wb_clk_i,
  input logic                 wb_rst_i,
  jtag_tap_responder_if.slave jtag
);

  typedef enum logic [3:0] {
    S_TLR, S_RTI,
    S_SEL_DR, S_CAP_DR, S_SH_DR, S_EX1_DR, S_PA_DR, S_EX2_DR, S_UPD_DR,
    S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PA_IR, S_EX2_IR, S_UPD_IR
  } tap_state_e;

  // Synchronizers. Left out of reset on purpose: the 3rd tck stage keeps
  // tracking the pin during reset so release never fakes an edge.
  logic [2:0] tck_q;
  logic [1:0] tms_q, tdi_q, trst_q;

  always_ff @(posedge wb_clk_i) begin
    tck_q  <= {tck_q[1:0], jtag.tck_i};
    tms_q  <= {tms_q[0], jtag.tms_i};
    tdi_q  <= {tdi_q[0], jtag.tdi_i};
    trst_q <= {trst_q[0], jtag.trst_n_i};
  end

  logic rst, tck_rise, tck_fall, tms, tdi;
  assign rst      = wb_rst_i | ~trst_q[1];
  assign tck_rise = tck_q[1] & ~tck_q[2];
  assign tck_fall = ~tck_q[1] & tck_q[2];
  assign tms      = tms_q[1];
  assign tdi      = tdi_q[1];

  tap_state_e  state, state_nxt;
  logic [3:0]  ir, ir_sr;
  logic [31:0] idcode_sr;
  logic        bypass_q, tdo_q, tdo_oe_q, chain_tdi_q;
  logic        cap_q, shift_q, upd_q;
  logic        cap_nxt, shift_nxt, upd_nxt;
  logic        sel_idcode, sel_scan, dr_tdo;

  assign sel_idcode = (ir == IR_IDCODE);
  assign sel_scan   = (ir == IR_SCAN);
  assign dr_tdo     = sel_idcode ? idcode_sr[0] :
                      sel_scan   ? jtag.chain_tdo_i : bypass_q;

  always_ff @(posedge wb_clk_i) begin
    if (rst) state <= S_TLR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap_nxt   = 1'b0;
    shift_nxt = 1'b0;
    upd_nxt   = 1'b0;
    if (tck_rise) begin
      unique case (state)
        S_TLR:    state_nxt = tms ? S_TLR    : S_RTI;
        S_RTI:    state_nxt = tms ? S_SEL_DR : S_RTI;
        S_SEL_DR: state_nxt = tms ? S_SEL_IR : S_CAP_DR;
        S_CAP_DR: state_nxt = tms ? S_EX1_DR : S_SH_DR;
        S_SH_DR:  state_nxt = tms ? S_EX1_DR : S_SH_DR;
        S_EX1_DR: state_nxt = tms ? S_UPD_DR : S_PA_DR;
        S_PA_DR:  state_nxt = tms ? S_EX2_DR : S_PA_DR;
        S_EX2_DR: state_nxt = tms ? S_UPD_DR : S_SH_DR;
        S_UPD_DR: state_nxt = tms ? S_SEL_DR : S_RTI;
        S_SEL_IR: state_nxt = tms ? S_TLR    : S_CAP_IR;
        S_CAP_IR: state_nxt = tms ? S_EX1_IR : S_SH_IR;
        S_SH_IR:  state_nxt = tms ? S_EX1_IR : S_SH_IR;
        S_EX1_IR: state_nxt = tms ? S_UPD_IR : S_PA_IR;
        S_PA_IR:  state_nxt = tms ? S_EX2_IR : S_PA_IR;
        S_EX2_IR: state_nxt = tms ? S_UPD_IR : S_SH_IR;
        S_UPD_IR: state_nxt = tms ? S_SEL_DR : S_RTI;
      endcase
      cap_nxt   = sel_scan && (state == S_CAP_DR);
      shift_nxt = sel_scan && (state == S_SH_DR);
    end
    if (tck_fall)
      upd_nxt = sel_scan && (state == S_UPD_DR);
  end

  // Datapath. Rise actions key off the state being left; fall actions key
  // off the state just entered. Pause states simply fall through.
  always_ff @(posedge wb_clk_i) begin
    if (rst) begin
      ir          <= IR_IDCODE;
      ir_sr       <= 4'b0;
      idcode_sr   <= IDCODE;
      bypass_q    <= 1'b0;
      tdo_q       <= 1'b0;
      tdo_oe_q    <= 1'b0;
      chain_tdi_q <= 1'b0;
      cap_q       <= 1'b0;
      shift_q     <= 1'b0;
      upd_q       <= 1'b0;
    end else begin
      cap_q   <= cap_nxt;
      shift_q <= shift_nxt;
      upd_q   <= upd_nxt;
      if (tck_rise) begin
        if (state == S_CAP_IR) ir_sr <= 4'b0101;
        if (state == S_SH_IR)  ir_sr <= {tdi, ir_sr[3:1]};
        if (state == S_CAP_DR) begin
          idcode_sr <= IDCODE;
          bypass_q  <= 1'b0;
        end
        if (state == S_SH_DR) begin
          if (sel_idcode) idcode_sr <= {tdi, idcode_sr[31:1]};
          if (sel_scan)   chain_tdi_q <= tdi;
          bypass_q <= tdi;
        end
        if (state_nxt == S_TLR) ir <= IR_IDCODE;
      end
      if (tck_fall) begin
        if (state == S_UPD_IR) ir <= ir_sr;
        tdo_q    <= (state == S_SH_IR) ? ir_sr[0] :
                    (state == S_SH_DR) ? dr_tdo   : 1'b0;
        tdo_oe_q <= (state == S_SH_IR) || (state == S_SH_DR);
      end
    end
  end

  assign jtag.tdo_o           = tdo_q;
  assign jtag.tdo_oe_o        = tdo_oe_q;
  assign jtag.ir_o            = ir;
  assign jtag.chain_tdi_o     = chain_tdi_q;
  assign jtag.chain_capture_o = cap_q;
  assign jtag.chain_shift_o   = shift_q;
  assign jtag.chain_update_o  = upd_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
module tb_jtag_tap_responder;
  localparam int          PH     = 5;
  localparam logic [31:0] IDCODE = 32'h1000_05FF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtag_tap_responder_if jif();
  jtag_tap_responder dut (.wb_clk_i(clk), .wb_rst_i(rst), .jtag(jif));

  // Behavioural scan chain: a 1-bit delay cleared on capture.
  logic loop_q = 1'b0;
  int   cap_cnt = 0, sh_cnt = 0, upd_cnt = 0;
  logic chain_q[$];
  assign jif.chain_tdo_i = loop_q;

  always @(posedge clk) begin
    if (jif.chain_capture_o) cap_cnt <= cap_cnt + 1;
    if (jif.chain_shift_o)   sh_cnt  <= sh_cnt + 1;
    if (jif.chain_update_o)  upd_cnt <= upd_cnt + 1;
    if (jif.chain_shift_o)   chain_q.push_back(jif.chain_tdi_o);
    if (jif.chain_capture_o)    loop_q <= 1'b0;
    else if (jif.chain_shift_o) loop_q <= jif.chain_tdi_o;
  end

  int         n_vec = 0, n_err = 0;
  logic       last_tdo, last_oe;
  logic [3:0] model_ir;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One tck period; tdo/oe are sampled late in the low phase.
  task automatic tck_cycle(input logic tms, input logic tdi);
    jif.tms_i = tms;
    jif.tdi_i = tdi;
    wait_clk(PH);
    jif.tck_i = 1'b1;
    wait_clk(PH);
    jif.tck_i = 1'b0;
    wait_clk(PH);
    last_tdo = jif.tdo_o;
    last_oe  = jif.tdo_oe_o;
  endtask

  // Shift n bits (exit on last), then Update and back to Run-Test/Idle.
  task automatic shift(input int n, input logic [63:0] din, output logic [63:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      dout[i] = last_tdo;
      chk("oe_shift", last_oe, 1);
      tck_cycle(i == n - 1, din[i]);
    end
    chk("oe_exit", last_oe, 0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  function automatic logic [63:0] lowmask(input int n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  // IR scan from Run-Test/Idle. Outgoing stream = captured 0101 then tdi bits;
  // new IR = the 4 stream bits that remain after n shifts.
  task automatic scan_ir(input int n, input logic [63:0] din);
    logic [63:0] s, dout;
    tck_cycle(1, 0); tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    s = ((din & lowmask(n)) << 4) | 64'h5;
    shift(n, din, dout);
    model_ir = 4'((s >> n) & 64'hF);
    chk("ir_tdo", dout & lowmask(n), s & lowmask(n));
    chk("ir_o", 64'(jif.ir_o), 64'(model_ir));
  endtask

  // DR scan from Run-Test/Idle against the register selected by model_ir.
  task automatic scan_dr(input int n, input logic [63:0] din);
    logic [63:0] s, dout, got_chain;
    int c0, s0, u0, q0;
    c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt; q0 = chain_q.size();
    tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    if (model_ir == 4'h1) s = ((din & lowmask(n)) << 32) | 64'(IDCODE);
    else                  s = (din & lowmask(n)) << 1;
    shift(n, din, dout);
    chk("dr_tdo", dout & lowmask(n), s & lowmask(n));
    if (model_ir == 4'h3) begin
      chk("cap_cnt", 64'(cap_cnt - c0), 1);
      chk("sh_cnt", 64'(sh_cnt - s0), 64'(n));
      chk("upd_cnt", 64'(upd_cnt - u0), 1);
      got_chain = '0;
      for (int i = 0; i < chain_q.size() - q0 && i < 64; i++) got_chain[i] = chain_q[q0 + i];
      chk("chain_tdi", got_chain, din & lowmask(n));
    end else begin
      chk("no_strobe", 64'((cap_cnt - c0) + (sh_cnt - s0) + (upd_cnt - u0)), 0);
    end
  endtask

  initial begin
    logic [63:0] d;
    int n, u0, c0, s0;
    logic [3:0] tgt;
    jif.tck_i = 0; jif.tms_i = 1; jif.tdi_i = 0; jif.trst_n_i = 1;
    last_tdo = 0; last_oe = 0;

    // Reset, then 10 tck with tms held high.
    wait_clk(8);
    chk("rst_ir", 64'(jif.ir_o), 4'h1);
    chk("rst_oe", 64'(jif.tdo_oe_o), 0);
    chk("rst_tdo", 64'(jif.tdo_o), 0);
    rst = 0;
    wait_clk(1);
    chk("rst_rel_strobe", 64'({jif.chain_capture_o, jif.chain_shift_o, jif.chain_update_o}), 0);
    c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
    for (int i = 0; i < 10; i++) tck_cycle(1, 0);
    chk("tlr_ir", 64'(jif.ir_o), 4'h1);
    chk("tlr_oe", 64'(last_oe), 0);
    chk("tlr_strobes", 64'((cap_cnt - c0) + (sh_cnt - s0) + (upd_cnt - u0)), 0);
    model_ir = 4'h1;
    tck_cycle(0, 0);

    // Directed: IDCODE read, IR load, bypass, scan chain.
    scan_dr(32, 64'($urandom));
    scan_ir(4, 64'h3);
    scan_ir(4, 64'hF);
    scan_dr(5, 64'b01101);
    scan_ir(4, 64'h3);
    scan_dr(8, 64'hA5);

    // trst_n dropped during the 4th Shift-DR bit with the chain selected.
    u0 = upd_cnt;
    tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    for (int i = 0; i < 3; i++) tck_cycle(0, 1);
    jif.tms_i = 0; jif.tdi_i = 1;
    wait_clk(PH);
    jif.tck_i = 1;
    wait_clk(PH);
    jif.trst_n_i = 0;
    wait_clk(6);
    chk("trst_ir", 64'(jif.ir_o), 4'h1);
    chk("trst_oe", 64'(jif.tdo_oe_o), 0);
    jif.trst_n_i = 1;
    jif.tck_i = 0;
    wait_clk(2 * PH);
    chk("trst_no_upd", 64'(upd_cnt - u0), 0);
    model_ir = 4'h1;
    tck_cycle(0, 0);
    scan_dr(32, 64'($urandom));

    // Five tms=1 rises from Shift-DR land in Test-Logic-Reset.
    scan_ir(4, 64'hF);
    tck_cycle(1, 0); tck_cycle(0, 0); tck_cycle(0, 0);
    for (int i = 0; i < 5; i++) tck_cycle(1, 0);
    model_ir = 4'h1;
    chk("tms5_ir", 64'(jif.ir_o), 4'h1);
    tck_cycle(0, 0);
    scan_dr(32, 64'($urandom));

    // Randomized IR/DR traffic.
    for (int it = 0; it < 10; it++) begin
      case ($urandom_range(0, 3))
        0:       tgt = 4'h1;
        1:       tgt = 4'h3;
        2:       tgt = 4'hF;
        default: tgt = 4'($urandom);
      endcase
      n = 4 + $urandom_range(0, 3);
      d = {$urandom, $urandom};
      d[n-4 +: 4] = tgt;
      scan_ir(n, d);
      chk("rand_ir", 64'(model_ir), 64'(tgt));
      scan_dr($urandom_range(1, 32), {$urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
